// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped read cache controller.
// Holds the FSM state encoding, default geometry, the tag-width helper
// and the event-counter width used by cache_controller and cache_line_store.
package cache_pkg;

   localparam int ADR_W_DEF  = 15;  // word-address width
   localparam int IDX_W_DEF  = 8;   // 256 lines
   localparam int CNT_W      = 16;  // hit/miss counter width
   localparam int WORD_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int LINE_W     = WORD_W * LINE_WORDS;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      LOOKUP,
      MEM_REQ,
      FILL,
      RESP
   } state_t;

   // Tag is what remains of the word address after index and 2-bit offset.
   function automatic int tag_w(input int adr_w, input int idx_w);
      return adr_w - idx_w - 2;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the direct-mapped cache: per-line valid bit, tag and
// four data words.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (valid bits only)
//   clr                 clears every valid bit in one cycle
//   rd_idx              read-port index; rd_valid/rd_tag/rd_line are combinational
//   wr_en, wr_idx,      write port: stores a whole line (tag + 4 words) and
//   wr_tag, wr_line     sets its valid bit; word 0 sits in wr_line[31:0]
module cache_line_store
   import cache_pkg::*;
#(
   parameter  int ADR_W = ADR_W_DEF,
   parameter  int IDX_W = IDX_W_DEF,
   localparam int TAG_W = tag_w(ADR_W, IDX_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];

   // Flush has priority over a fill; the controller never requests both at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (clr) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag/data arrays carry no reset; the valid bit alone decides whether
   // their contents mean anything, and an unreset array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, read-only cache controller with 4-word lines.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cpu_rd, cpu_adr         read request pulse and word address (taken in IDLE)
//   flush                   invalidate-all pulse (taken in IDLE, beats cpu_rd)
//   cpu_data, cpu_ready,    registered response: one-cycle ready pulse with
//   cpu_hit                 data and hit/miss qualifier
//   cpu_busy                high whenever the FSM is not in IDLE
//   mem_start, mem_forc,    block-read handshake with data memory: start is held
//   mem_adr, mem_ready,     until ready, forc clears ready; block words at
//   mem_r1..mem_r4          offsets 0..3 arrive on mem_r1..mem_r4
//   hit_cnt, miss_cnt       saturating event counters (cleared only by reset)
module cache_controller
   import cache_pkg::*;
#(
   parameter int ADR_W = ADR_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_rd,
   input  logic [ADR_W-1:0] cpu_adr,
   input  logic             flush,
   output logic [31:0]      cpu_data,
   output logic             cpu_ready,
   output logic             cpu_hit,
   output logic             cpu_busy,
   output logic             mem_start,
   output logic             mem_forc,
   output logic [ADR_W-1:0] mem_adr,
   input  logic             mem_ready,
   input  logic [31:0]      mem_r1,
   input  logic [31:0]      mem_r2,
   input  logic [31:0]      mem_r3,
   input  logic [31:0]      mem_r4,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int TAG_W = tag_w(ADR_W, IDX_W);

   state_t state, next_state;

   logic [ADR_W-1:0]  adr_q;
   logic              hit_q;
   logic              st_valid;
   logic [TAG_W-1:0]  st_tag;
   logic [LINE_W-1:0] st_line;
   logic              lookup_hit;
   logic              flush_clr;

   wire [IDX_W-1:0] idx = adr_q[IDX_W+1:2];
   wire [TAG_W-1:0] tag = adr_q[ADR_W-1:IDX_W+2];
   wire [1:0]       off = adr_q[1:0];

   assign lookup_hit = st_valid && (st_tag == tag);
   assign flush_clr  = (state == IDLE) && flush;

   cache_line_store #(
      .ADR_W (ADR_W),
      .IDX_W (IDX_W)
   ) u_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush_clr),
      .rd_idx   (idx),
      .rd_valid (st_valid),
      .rd_tag   (st_tag),
      .rd_line  (st_line),
      .wr_en    (state == FILL),
      .wr_idx   (idx),
      .wr_tag   (tag),
      .wr_line  ({mem_r4, mem_r3, mem_r2, mem_r1})
   );

   // NOTE: state and every registered output use non-blocking assignments so
   // all flops sample the same pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= INIT;
      else        state <= next_state;
   end

   // NOTE: next_state gets its default before the case so no path through the
   // block leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         INIT:    next_state = IDLE;
         IDLE:    if (!flush && cpu_rd) next_state = LOOKUP;
         LOOKUP:  next_state = lookup_hit ? RESP : MEM_REQ;
         MEM_REQ: if (mem_ready) next_state = FILL;
         FILL:    next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = INIT;
      endcase
   end

   // Outputs are registered. mem_start/mem_forc are decoded from next_state so
   // they are high while the FSM sits in MEM_REQ/FILL; the INIT forc pulse
   // appears in the cycle after INIT. Since next_state cannot be MEM_REQ and
   // FILL at once, and INIT never leads to MEM_REQ, the two never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q     <= '0;
         hit_q     <= 1'b0;
         cpu_data  <= '0;
         cpu_ready <= 1'b0;
         cpu_hit   <= 1'b0;
         cpu_busy  <= 1'b1;
         mem_start <= 1'b0;
         mem_forc  <= 1'b0;
         mem_adr   <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         if (state == IDLE && cpu_rd && !flush) adr_q <= cpu_adr;
         if (state == LOOKUP) begin
            hit_q <= lookup_hit;
            if (!lookup_hit) mem_adr <= {adr_q[ADR_W-1:2], 2'b00};
            if (lookup_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
         end
         if (state == FILL && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
         // The line is already in the store during RESP, for hits and fills alike.
         if (state == RESP) cpu_data <= st_line[{off, 5'b0} +: 32];
         cpu_ready <= (state == RESP);
         cpu_hit   <= (state == RESP) && hit_q;
         cpu_busy  <= (next_state != IDLE);
         mem_start <= (next_state == MEM_REQ);
         mem_forc  <= (state == INIT) || (next_state == FILL);
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
// Memory model: word i holds value i; mem_ready rises after mem_start has been
// seen for MEM_DLY edges and is cleared by mem_forc.
module tb_cache_controller;
   import cache_pkg::*;

   localparam int MEM_DLY  = 3;
   localparam int HIT_LAT  = 2;
   localparam int MISS_LAT = 4 + MEM_DLY;

   typedef struct {
      logic [31:0] data;
      logic        hit;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_rd;
   logic [14:0] cpu_adr;
   logic        flush;
   logic [31:0] cpu_data;
   logic        cpu_ready;
   logic        cpu_hit;
   logic        cpu_busy;
   logic        mem_start;
   logic        mem_forc;
   logic [14:0] mem_adr;
   logic        mem_ready;
   logic [31:0] mem_r1, mem_r2, mem_r3, mem_r4;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb[$];

   int          ready_cnt   = 0;
   int          start_cnt   = 0;
   int          overlap_cnt = 0;
   int          dly_cnt     = 0;
   logic [14:0] last_mem_adr = '0;

   cache_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_rd    (cpu_rd),
      .cpu_adr   (cpu_adr),
      .flush     (flush),
      .cpu_data  (cpu_data),
      .cpu_ready (cpu_ready),
      .cpu_hit   (cpu_hit),
      .cpu_busy  (cpu_busy),
      .mem_start (mem_start),
      .mem_forc  (mem_forc),
      .mem_adr   (mem_adr),
      .mem_ready (mem_ready),
      .mem_r1    (mem_r1),
      .mem_r2    (mem_r2),
      .mem_r3    (mem_r3),
      .mem_r4    (mem_r4),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Block memory: word i = i.
   assign mem_r1 = 32'(mem_adr);
   assign mem_r2 = 32'(mem_adr) + 32'd1;
   assign mem_r3 = 32'(mem_adr) + 32'd2;
   assign mem_r4 = 32'(mem_adr) + 32'd3;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ready <= 1'b0;
         dly_cnt   <= 0;
      end else if (mem_forc) begin
         mem_ready <= 1'b0;
         dly_cnt   <= 0;
      end else if (mem_start) begin
         dly_cnt <= dly_cnt + 1;
         if (dly_cnt + 1 == MEM_DLY) mem_ready <= 1'b1;
      end
   end

   // Event monitors (not reset with the DUT).
   always @(posedge clk) begin
      if (cpu_ready) ready_cnt <= ready_cnt + 1;
      if (mem_start) begin
         start_cnt    <= start_cnt + 1;
         last_mem_adr <= mem_adr;
      end
      if (mem_start && mem_forc) overlap_cnt <= overlap_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one read; the expected response goes on the scoreboard and is
   // popped when cpu_ready appears. With poke=1, cpu_rd is held for one more
   // cycle (while busy) with a different address, which must be ignored.
   task automatic do_read(input logic [14:0] adr, input logic exp_hit, input bit poke);
      exp_t e;
      exp_t got_e;
      int   lat;
      bit   got;
      e.data = 32'(adr);
      e.hit  = exp_hit;
      e.lat  = exp_hit ? HIT_LAT : MISS_LAT;
      sb.push_back(e);
      cpu_rd  = 1'b1;
      cpu_adr = adr;
      tick();                          // request edge
      if (poke) cpu_adr = 15'h0100;
      else      cpu_rd  = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 50) begin
         tick();
         lat++;
         cpu_rd = 1'b0;
         if (cpu_ready) got = 1'b1;
      end
      check($sformatf("ready_seen_%0h", adr), 32'(got), 32'd1);
      got_e = sb.pop_front();
      check($sformatf("data_%0h", adr), cpu_data, got_e.data);
      check($sformatf("hit_%0h", adr), 32'(cpu_hit), 32'(got_e.hit));
      check($sformatf("latency_%0h", adr), 32'(lat), 32'(got_e.lat));
      tick();
      check($sformatf("ready_one_cycle_%0h", adr), 32'(cpu_ready), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
      check({tag, "_cpu_hit"},   32'(cpu_hit),   32'd0);
      check({tag, "_mem_start"}, 32'(mem_start), 32'd0);
      check({tag, "_mem_forc"},  32'(mem_forc),  32'd0);
      check({tag, "_cpu_data"},  cpu_data,       32'd0);
      check({tag, "_mem_adr"},   32'(mem_adr),   32'd0);
      check({tag, "_hit_cnt"},   32'(hit_cnt),   32'd0);
      check({tag, "_miss_cnt"},  32'(miss_cnt),  32'd0);
      check({tag, "_cpu_busy"},  32'(cpu_busy),  32'd1);
   endtask

   // Release reset and confirm the single post-INIT mem_forc pulse.
   task automatic release_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check({tag, "_init_forc"},  32'(mem_forc),  32'd1);
      check({tag, "_init_start"}, 32'(mem_start), 32'd0);
      tick();
      check({tag, "_forc_drop"},  32'(mem_forc),  32'd0);
      check({tag, "_idle_busy"},  32'(cpu_busy),  32'd0);
   endtask

   initial begin
      int rc;
      int sc;
      int n;
      rst_n   = 1'b0;
      cpu_rd  = 1'b0;
      cpu_adr = '0;
      flush   = 1'b0;

      // Reset state
      #13;
      check_reset_outputs("reset");
      release_reset("reset");

      // Cold miss
      do_read(15'h0005, 1'b0, 1'b0);
      check("cold_mem_adr", 32'(last_mem_adr), 32'h0004);
      check("cold_miss_cnt", 32'(miss_cnt), 32'd1);
      check("cold_hit_cnt", 32'(hit_cnt), 32'd0);

      // Hit in the same line, no memory traffic
      sc = start_cnt;
      do_read(15'h0006, 1'b1, 1'b0);
      check("hit_no_start", 32'(start_cnt - sc), 32'd0);
      check("hit_cnt_1", 32'(hit_cnt), 32'd1);

      // Conflict on index 1
      do_read(15'h0405, 1'b0, 1'b0);
      check("conflict_mem_adr", 32'(last_mem_adr), 32'h0404);
      do_read(15'h0005, 1'b0, 1'b0);
      check("conflict_miss_cnt", 32'(miss_cnt), 32'd3);

      // Flush, then re-read misses; counters survive flush
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_keeps_hit_cnt", 32'(hit_cnt), 32'd1);
      check("flush_idle_busy", 32'(cpu_busy), 32'd0);
      do_read(15'h0006, 1'b0, 1'b0);
      check("flush_miss_cnt", 32'(miss_cnt), 32'd4);

      // Flush and read together: read dropped, line invalidated
      rc      = ready_cnt;
      flush   = 1'b1;
      cpu_rd  = 1'b1;
      cpu_adr = 15'h0006;
      tick();
      flush  = 1'b0;
      cpu_rd = 1'b0;
      check("flush_rd_busy", 32'(cpu_busy), 32'd0);
      for (int i = 0; i < 12; i++) tick();
      check("flush_rd_no_ready", 32'(ready_cnt - rc), 32'd0);
      do_read(15'h0006, 1'b0, 1'b0);
      check("flush_rd_miss_cnt", 32'(miss_cnt), 32'd5);

      // cpu_rd while busy is ignored
      rc = ready_cnt;
      do_read(15'h0007, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) tick();
      check("busy_rd_one_ready", 32'(ready_cnt - rc), 32'd1);
      check("busy_rd_hit_cnt", 32'(hit_cnt), 32'd2);
      check("busy_rd_miss_cnt", 32'(miss_cnt), 32'd5);

      // Reset in the middle of MEM_REQ
      rc      = ready_cnt;
      cpu_rd  = 1'b1;
      cpu_adr = 15'h0209;
      tick();
      cpu_rd = 1'b0;
      n = 0;
      while (!mem_start && n < 20) begin
         tick();
         n++;
      end
      check("memreq_reached", 32'(mem_start), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreq");
      release_reset("midreq");
      for (int i = 0; i < 10; i++) tick();
      check("midreq_no_ready", 32'(ready_cnt - rc), 32'd0);
      do_read(15'h0209, 1'b0, 1'b0);
      check("midreq_mem_adr", 32'(last_mem_adr), 32'h0208);
      check("midreq_miss_cnt", 32'(miss_cnt), 32'd1);

      // Global properties
      check("start_forc_overlap", 32'(overlap_cnt), 32'd0);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter ADR_W, default 15, SHALL set the word-address width.
REQ-002 Parameter IDX_W, default 8, SHALL set the index width: 256 lines of 4 words each, tag width ADR_W-IDX_W-2 = 5.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port cpu_rd, input, 1: single-cycle read request pulse.
REQ-006 Port cpu_adr, input, ADR_W: word address, sampled with cpu_rd.
REQ-007 Port flush, input, 1: single-cycle invalidate-all pulse.
REQ-008 Port cpu_data, output, 32: read data, valid while cpu_ready=1.
REQ-009 Port cpu_ready, output, 1: one-cycle completion pulse.
REQ-010 Port cpu_hit, output, 1: qualifies cpu_ready; 1 = hit, 0 = miss.
REQ-011 Port cpu_busy, output, 1: high in every state except IDLE.
REQ-012 Port mem_start, output, 1: block-read request to data memory.
REQ-013 Port mem_forc, output, 1: clears the memory ready flag.
REQ-014 Port mem_adr, output, ADR_W: block-aligned memory address.
REQ-015 Port mem_ready, input, 1: memory block valid.
REQ-016 Ports mem_r1..mem_r4, input, 32 each: block words at offsets 0..3.
REQ-017 Ports hit_cnt and miss_cnt, output, 16 each: saturating event counters.

Function
REQ-018 Address split SHALL be: offset = adr[1:0], index = adr[9:2], tag = adr[14:10].
REQ-019 The FSM SHALL have the states INIT, IDLE, LOOKUP, MEM_REQ, FILL and RESP.
REQ-020 INIT SHALL last exactly one cycle with mem_forc=1 to clear any stale memory ready, then go to IDLE.
REQ-021 In IDLE, flush=1 SHALL clear all valid bits in one cycle and keep the FSM in IDLE.
REQ-022 When flush=1 and cpu_rd=1 arrive together in IDLE, flush SHALL win and the read SHALL be dropped.
REQ-023 In IDLE, cpu_rd=1 SHALL latch cpu_adr and go to LOOKUP.
REQ-024 cpu_rd and flush SHALL be ignored in every state other than IDLE.
REQ-025 In LOOKUP, valid and tag-equal SHALL count as a hit and go to RESP with cpu_hit=1 and hit_cnt incremented.
REQ-026 In LOOKUP, a miss SHALL go to MEM_REQ with mem_adr = {tag, index, 2'b00}.
REQ-027 In MEM_REQ, mem_start SHALL be held at 1 until mem_ready=1 is sampled, then the FSM SHALL go to FILL.
REQ-028 In FILL, the controller SHALL write mem_r1..mem_r4 to the line, set its tag and valid bit, and drive mem_start=0 and mem_forc=1 for one cycle.
REQ-029 After FILL, the FSM SHALL go to RESP with cpu_hit=0 and miss_cnt incremented.
REQ-030 In RESP, cpu_ready SHALL be 1 for exactly one cycle, cpu_data SHALL be the word at the latched offset, and the FSM SHALL return to IDLE.
REQ-031 Hit latency SHALL be 2 cycles from the request edge to cpu_ready.
REQ-032 Miss latency SHALL be 4 cycles plus the mem_ready wait.
REQ-033 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF and SHALL NOT be cleared by flush.
REQ-034 mem_start and mem_forc SHALL never be high in the same cycle.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 rst_n=0 SHALL immediately force: state INIT, all valid bits 0, cpu_ready/cpu_hit/mem_start/mem_forc 0, cpu_data 0, mem_adr 0, both counters 0.
REQ-037 Reset in any state, including mid-MEM_REQ, SHALL abandon the transaction with no line fill and no cpu_ready.
REQ-038 Tag and data arrays need not be reset.

Structure
REQ-039 A shared package cache_pkg SHALL hold the state enum, ADR_W/IDX_W defaults, the tag-width function and the counter width.
REQ-040 One sub-module, cache_line_store, SHALL hold the tag/valid/data arrays with one read port and one 4-word write port.
REQ-041 The valid bits in cache_line_store SHALL have an asynchronous clear and a flush clear.

Verification (memory model: word i = i)
REQ-042 Cold read 0x0005 SHALL produce mem_adr=0x0004, then cpu_data=0x00000005, cpu_hit=0, miss_cnt=1.
REQ-043 A following read of 0x0006 SHALL produce cpu_data=0x00000006, cpu_hit=1 at 2 cycles with no mem_start, hit_cnt=1.
REQ-044 Conflict: read 0x0405 SHALL miss with data 0x405, and a re-read of 0x0005 SHALL miss again, giving miss_cnt=3.
REQ-045 flush then read 0x0006 SHALL miss, while a simultaneous flush+cpu_rd SHALL produce no cpu_ready.
REQ-046 rst_n low during MEM_REQ SHALL zero all outputs, be followed by a one-cycle mem_forc, and yield no cpu_ready.
REQ-047 A cpu_rd pulse while cpu_busy=1 SHALL be ignored, giving exactly one cpu_ready.
